db_event_arbiter: RTL
=====================

Name: db_event_arbiter

Overview:
- Converts up to N_BTN debounced button levels into discrete press events: short press, reported on release, or long press, reported once the hold threshold is reached.
- Arbitrates simultaneous events round-robin into a single valid/ready event stream.
- Sits between the bank of DB_debouncer instances and the control FSM that consumes user input.

Parameters:
- N_BTN, 4: number of button inputs (1..16).
- LONG_LIMIT, 1000: hold length in clk cycles at which a press becomes long (>=2).
- REPEAT_PERIOD, 250: auto-repeat interval in cycles (>=1). Used only with DB_AUTO_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- btn_in, input, N_BTN: debounced button levels (DB_debouncer signal outputs), synchronous to clk.
- evt_valid, output, 1: event present on evt_id/evt_long.
- evt_ready, input, 1: consumer accepts the event when evt_valid & evt_ready at a clk edge.
- evt_id, output, ID_W: index of the button that produced the event. ID_W = max(1, $clog2(N_BTN)).
- evt_long, output, 1: 1 = long/repeat event, 0 = short event.
- ovf_clr, input, 1: synchronous clear of evt_overflow.
- evt_overflow, output, 1: sticky flag; a pending event was overwritten before it was granted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all state cleared. evt_valid=0, evt_id=0, evt_long=0, evt_overflow=0, all hold counters 0, all prev levels 0, all pending flags 0. Round-robin pointer last_grant = N_BTN-1, so button 0 has first priority.
- A button held through reset deasserts prev; it is seen as a new press on the first edge after reset.
- Per-button detection, with hold counter width $clog2(LONG_LIMIT+1):
  - Rise (btn_in=1, prev=0): counter <= 1.
  - Held (btn_in=1, prev=1): counter increments, saturating at LONG_LIMIT. On the edge where counter goes LONG_LIMIT-1 -> LONG_LIMIT, generate a long event. This happens exactly once per press.
  - Fall (btn_in=0, prev=1): if counter < LONG_LIMIT, generate a short event. Otherwise generate nothing. Counter <= 0.
  - prev <= btn_in every cycle.
- Pending slot per button (pend, pend_long):
  - An event generated at edge k sets pend (and pend_long = type) after edge k.
  - If pend is already set and the slot is not granted at the same edge, the slot is overwritten with the new type and evt_overflow is set.
  - If the slot is granted at the same edge, the new event is stored with no overflow.
  - ovf_clr clears evt_overflow. If ovf_clr and a new overflow occur in the same cycle, the overflow wins (flag stays 1).
- Arbitration:
  - The output register is free when evt_valid=0 or (evt_valid & evt_ready).
  - When free and any pend is set, grant the first pending button searching last_grant+1, last_grant+2, ... modulo N_BTN.
  - On grant: load evt_id/evt_long, set evt_valid, clear that pend, set last_grant = granted index.
  - When free and nothing is pending, evt_valid <= 0.
- Latency: a btn_in edge sampled at edge k sets pend at k. evt_valid is asserted after edge k+1 if the output is free. Back-to-back events are supported at one per cycle while evt_ready=1.
- Handshake: evt_id/evt_long are held stable while evt_valid & !evt_ready. evt_valid never drops without acceptance, except on reset.
- Reset mid-operation: pending and in-flight events are discarded. No event is emitted for a press that was interrupted by reset.

Optional Feature:
- Macro: DB_AUTO_REPEAT_EN.
- Defined:
  - Per-button repeat counter, width $clog2(REPEAT_PERIOD+1).
  - After the long event, while the button stays held, one additional long event (evt_long=1) is generated every REPEAT_PERIOD cycles.
  - The repeat counter resets on each long or repeat event and on release.
  - Repeats use the same pending slot and follow the same overflow rules.
- Not defined: exactly one long event per press; no repeat counters are synthesized.

Test Plan (bench parameters N_BTN=4, LONG_LIMIT=8, REPEAT_PERIOD=4, evt_ready=1 unless stated):
- Short press: btn_in[2] high for 3 cycles then low -> one event, evt_id=2, evt_long=0. evt_valid is asserted 2 cycles after the falling-edge sample.
- Long press: btn_in[1] held 20 cycles -> one event evt_id=1, evt_long=1, 2 cycles after the 8th held cycle. No event on release.
- Simultaneous events with round-robin: short presses released on the same cycle on buttons 0, 1 and 3, after reset -> evt_id sequence 0, 1, 3 on consecutive cycles. Repeat with last_grant=1 -> order 3, 0, 1.
- Backpressure and overflow: evt_ready=0, button 2 gives 2 short presses and button 0 gives 1 short press -> first event held stable. evt_overflow=1 after the second button-2 event. ovf_clr=1 for 1 cycle -> evt_overflow=0.
- Reset mid-press: assert rst_n low while btn_in[3] is held with evt_valid=1 -> all outputs 0 immediately. Release rst_n with the button still held, then release the button after 3 cycles -> exactly one short event, id 3.
- DB_AUTO_REPEAT_EN defined: btn_in[0] held 20 cycles -> long events on held cycles 8, 12, 16 and 20 (4 events, all evt_long=1). Macro undefined -> 1 event.

Source files
------------

// File: rtl/db_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : db_event_arbiter
// Brief    : Turns debounced button levels into short/long press events and
//            arbitrates them round-robin onto one valid/ready stream.
//            Optional macro DB_AUTO_REPEAT_EN adds held-button auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module db_event_arbiter #(
    parameter int N_BTN         = 4,
    parameter int LONG_LIMIT    = 1000,
    parameter int REPEAT_PERIOD = 250,
    localparam int ID_W         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_long,
    input  logic             ovf_clr,
    output logic             evt_overflow
);

    localparam int            CW         = $clog2(LONG_LIMIT + 1);
    localparam logic [CW-1:0] c_limit    = CW'(LONG_LIMIT);
    localparam logic [CW-1:0] c_limit_m1 = CW'(LONG_LIMIT - 1);
`ifdef DB_AUTO_REPEAT_EN
    localparam int            RW         = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD + 1) : 1;
    localparam logic [RW-1:0] c_rep_m1   = RW'(REPEAT_PERIOD - 1);
`endif

    if (N_BTN < 1 || N_BTN > 16 || LONG_LIMIT < 2 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("db_event_arbiter: parameter out of range");
    end

    logic [N_BTN-1:0] r_prev;
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_pend_long;
    logic [ID_W-1:0]  r_last_grant;
    logic [N_BTN-1:0] w_gen;
    logic [N_BTN-1:0] w_gen_long;
    logic [N_BTN-1:0] w_grant_mask;
    logic [ID_W-1:0]  w_grant_idx;
    logic [ID_W-1:0]  w_cand;
    logic             w_grant_vld;
    logic             w_free;
    logic             w_grant;
    logic             w_ovf_hit;

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        logic [CW-1:0] r_cnt;
        logic          w_held;
        logic          w_fall;
        logic          w_long;
        logic          w_short;

        assign w_held  = btn_in[b] & r_prev[b];
        assign w_fall  = ~btn_in[b] & r_prev[b];
        assign w_long  = w_held & (r_cnt == c_limit_m1);
        assign w_short = w_fall & (r_cnt < c_limit);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (btn_in[b] & ~r_prev[b]) begin
                r_cnt <= CW'(1);
            end else if (w_held && (r_cnt != c_limit)) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_fall) begin
                r_cnt <= '0;
            end
        end

`ifdef DB_AUTO_REPEAT_EN
        logic [RW-1:0] r_rep;
        logic          w_rep;

        assign w_rep = w_held & (r_cnt == c_limit) & (r_rep == c_rep_m1);

        // Repeat phase restarts at every long/repeat event and whenever the button is not held.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rep <= '0;
            end else if (w_long || w_rep || !w_held) begin
                r_rep <= '0;
            end else if (r_cnt == c_limit) begin
                r_rep <= r_rep + 1'b1;
            end
        end

        assign w_gen[b]      = w_long | w_rep | w_short;
        assign w_gen_long[b] = w_long | w_rep;
`else
        assign w_gen[b]      = w_long | w_short;
        assign w_gen_long[b] = w_long;
`endif
    end

    // Descending scan so the last hit is the lowest offset after last_grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = N_BTN; i >= 1; i--) begin
            w_cand = ID_W'((int'(r_last_grant) + i) % N_BTN);
            if (r_pend[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_free  = ~evt_valid | evt_ready;
    assign w_grant = w_free & w_grant_vld;

    always_comb begin
        w_grant_mask = '0;
        if (w_grant) begin
            w_grant_mask[w_grant_idx] = 1'b1;
        end
    end

    assign w_ovf_hit = |(w_gen & r_pend & ~w_grant_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_pend       <= '0;
            r_pend_long  <= '0;
            r_last_grant <= ID_W'(N_BTN - 1);
            evt_valid    <= 1'b0;
            evt_id       <= '0;
            evt_long     <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            r_prev <= btn_in;
            for (int b = 0; b < N_BTN; b++) begin
                if (w_gen[b]) begin
                    r_pend[b]      <= 1'b1;
                    r_pend_long[b] <= w_gen_long[b];
                end else if (w_grant_mask[b]) begin
                    r_pend[b]      <= 1'b0;
                end
            end
            if (w_ovf_hit) begin
                evt_overflow <= 1'b1;
            end else if (ovf_clr) begin
                evt_overflow <= 1'b0;
            end
            if (w_free) begin
                if (w_grant_vld) begin
                    evt_valid    <= 1'b1;
                    evt_id       <= w_grant_idx;
                    evt_long     <= r_pend_long[w_grant_idx];
                    r_last_grant <= w_grant_idx;
                end else begin
                    evt_valid    <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
